// File: rtl/l2_access_arbiter_if.sv
// Bundle of L1-side request/response and L2-side channel signals around the
// L1<->L2 access arbiter. The arbiter takes the slave view; the L1 caches and
// the L2 together take the master view.
//
// Handshake rule for every request channel: the source holds VALID and its
// payload steady until the matching READY is sampled high at a clock edge;
// a transfer happens on exactly that edge. Completion and data-valid pulses
// are single-cycle and are not back-pressured.
interface l2_access_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int L2_BUS_WIDTH  = 32
);
    localparam int WAW = ADDRESS_WIDTH - 2;

    logic                    IC_RD_VALID;
    logic                    IC_RD_READY;
    logic [WAW-1:0]          IC_RD_ADDR;
    logic                    DC_RD_VALID;
    logic                    DC_RD_READY;
    logic [WAW-1:0]          DC_RD_ADDR;
    logic                    DC_WR_VALID;
    logic                    DC_WR_READY;
    logic [WAW-1:0]          DC_WR_ADDR;
    logic [L2_BUS_WIDTH-1:0] DC_WR_DATA;
    logic                    DC_WR_COMPLETE;
    logic [L2_BUS_WIDTH-1:0] RD_DATA_OUT;
    logic                    IC_RD_DATA_VALID;
    logic                    DC_RD_DATA_VALID;
    logic                    L2_RD_ADDR_VALID;
    logic                    L2_RD_ADDR_READY;
    logic [WAW-1:0]          L2_RD_ADDR;
    logic                    L2_DATA_VALID;
    logic                    L2_DATA_READY;
    logic [L2_BUS_WIDTH-1:0] L2_DATA;
    logic                    L2_WR_VALID;
    logic                    L2_WR_READY;
    logic [WAW-1:0]          L2_WR_ADDR;
    logic [L2_BUS_WIDTH-1:0] L2_WR_DATA;
    logic                    L2_WR_COMPLETE;

    modport slave (
        input  IC_RD_VALID, IC_RD_ADDR,
        input  DC_RD_VALID, DC_RD_ADDR,
        input  DC_WR_VALID, DC_WR_ADDR, DC_WR_DATA,
        output IC_RD_READY, DC_RD_READY, DC_WR_READY, DC_WR_COMPLETE,
        output RD_DATA_OUT, IC_RD_DATA_VALID, DC_RD_DATA_VALID,
        output L2_RD_ADDR_VALID, L2_RD_ADDR, L2_DATA_READY,
        output L2_WR_VALID, L2_WR_ADDR, L2_WR_DATA,
        input  L2_RD_ADDR_READY, L2_DATA_VALID, L2_DATA,
        input  L2_WR_READY, L2_WR_COMPLETE
    );

    modport master (
        output IC_RD_VALID, IC_RD_ADDR,
        output DC_RD_VALID, DC_RD_ADDR,
        output DC_WR_VALID, DC_WR_ADDR, DC_WR_DATA,
        input  IC_RD_READY, DC_RD_READY, DC_WR_READY, DC_WR_COMPLETE,
        input  RD_DATA_OUT, IC_RD_DATA_VALID, DC_RD_DATA_VALID,
        input  L2_RD_ADDR_VALID, L2_RD_ADDR, L2_DATA_READY,
        input  L2_WR_VALID, L2_WR_ADDR, L2_WR_DATA,
        output L2_RD_ADDR_READY, L2_DATA_VALID, L2_DATA,
        output L2_WR_READY, L2_WR_COMPLETE
    );
endinterface

// File: rtl/l2_access_arbiter.sv
// Round-robin arbiter sharing the single L2 port between IC reads, DC reads
// and DC writes. One transaction in flight; grants happen only in IDLE.
// state_dbg exposes the FSM state (IDLE=0 RD_ADDR=1 RD_DATA=2 WR_ADDR=3 WR_WAIT=4).
module l2_access_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int L2_BUS_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    l2_access_arbiter_if.slave    bus,
    output logic [2:0]            state_dbg
);
    localparam int WAW = ADDRESS_WIDTH - 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_ADDR = 3'd3,
        S_WR_WAIT = 3'd4
    } state_t;

    localparam logic [1:0] REQ_IC    = 2'd0;
    localparam logic [1:0] REQ_DC_RD = 2'd1;
    localparam logic [1:0] REQ_DC_WR = 2'd2;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              last_grant;
    logic                    owner_ic;
    logic                    grant_ic;
    logic                    grant_dc_rd;
    logic                    grant_dc_wr;
    logic [WAW-1:0]          rd_addr_sel;
    logic [L2_BUS_WIDTH-1:0] rd_word_q;

    assign state_dbg       = state;
    assign bus.RD_DATA_OUT = rd_word_q;

    // Round-robin pick: search starts at the requester after the last winner.
    always_comb begin
        grant_ic    = 1'b0;
        grant_dc_rd = 1'b0;
        grant_dc_wr = 1'b0;
        if (state == S_IDLE && !RST) begin
            case (last_grant)
                REQ_IC: begin
                    if (bus.DC_RD_VALID)      grant_dc_rd = 1'b1;
                    else if (bus.DC_WR_VALID) grant_dc_wr = 1'b1;
                    else if (bus.IC_RD_VALID) grant_ic    = 1'b1;
                end
                REQ_DC_RD: begin
                    if (bus.DC_WR_VALID)      grant_dc_wr = 1'b1;
                    else if (bus.IC_RD_VALID) grant_ic    = 1'b1;
                    else if (bus.DC_RD_VALID) grant_dc_rd = 1'b1;
                end
                default: begin
                    if (bus.IC_RD_VALID)      grant_ic    = 1'b1;
                    else if (bus.DC_RD_VALID) grant_dc_rd = 1'b1;
                    else if (bus.DC_WR_VALID) grant_dc_wr = 1'b1;
                end
            endcase
        end
    end

    // Read address of whichever reader wins this cycle.
    always_comb begin
        rd_addr_sel = grant_ic ? bus.IC_RD_ADDR : bus.DC_RD_ADDR;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; L2 responses outside their own state are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_ic || grant_dc_rd) state_nxt = S_RD_ADDR;
                else if (grant_dc_wr)        state_nxt = S_WR_ADDR;
            end
            S_RD_ADDR: if (bus.L2_RD_ADDR_READY) state_nxt = S_RD_DATA;
            S_RD_DATA: if (bus.L2_DATA_VALID)    state_nxt = S_IDLE;
            S_WR_ADDR: if (bus.L2_WR_READY)      state_nxt = S_WR_WAIT;
            S_WR_WAIT: if (bus.L2_WR_COMPLETE)   state_nxt = S_IDLE;
            default:                             state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; forced low while reset is held.
    always_comb begin
        bus.IC_RD_READY      = grant_ic;
        bus.DC_RD_READY      = grant_dc_rd;
        bus.DC_WR_READY      = grant_dc_wr;
        bus.L2_RD_ADDR_VALID = !RST && (state == S_RD_ADDR);
        bus.L2_DATA_READY    = !RST && (state == S_RD_DATA);
        bus.L2_WR_VALID      = !RST && (state == S_WR_ADDR);
    end

    // Capture granted payload, track owner/pointer, and emit one-cycle return pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant           <= REQ_DC_WR;
            owner_ic             <= 1'b0;
            bus.L2_RD_ADDR       <= '0;
            bus.L2_WR_ADDR       <= '0;
            bus.L2_WR_DATA       <= '0;
            rd_word_q            <= '0;
            bus.IC_RD_DATA_VALID <= 1'b0;
            bus.DC_RD_DATA_VALID <= 1'b0;
            bus.DC_WR_COMPLETE   <= 1'b0;
        end else begin
            bus.IC_RD_DATA_VALID <= 1'b0;
            bus.DC_RD_DATA_VALID <= 1'b0;
            bus.DC_WR_COMPLETE   <= 1'b0;
            if (grant_ic || grant_dc_rd) begin
                bus.L2_RD_ADDR <= rd_addr_sel;
                owner_ic       <= grant_ic;
                last_grant     <= grant_ic ? REQ_IC : REQ_DC_RD;
            end
            if (grant_dc_wr) begin
                bus.L2_WR_ADDR <= bus.DC_WR_ADDR;
                bus.L2_WR_DATA <= bus.DC_WR_DATA;
                last_grant     <= REQ_DC_WR;
            end
            if (state == S_RD_DATA && bus.L2_DATA_VALID) begin
                rd_word_q            <= bus.L2_DATA;
                bus.IC_RD_DATA_VALID <= owner_ic;
                bus.DC_RD_DATA_VALID <= !owner_ic;
            end
            if (state == S_WR_WAIT && bus.L2_WR_COMPLETE) begin
                bus.DC_WR_COMPLETE <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_l2_access_arbiter.sv
// Directed bench for l2_access_arbiter. Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_l2_access_arbiter;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] state_dbg;
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [31:0] exp_q[$];

    // Per-cycle expectations for the round-robin run with L2 answering at once.
    // ready = {DC_WR, DC_RD, IC}; pulse = {DC_WR_COMPLETE, DC_RD_DATA_VALID, IC_RD_DATA_VALID}
    localparam logic [2:0] RR_STATE [10] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd0};
    localparam logic [2:0] RR_RDY   [10] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001};
    localparam logic [2:0] RR_PULSE [10] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100};

    l2_access_arbiter_if #(.ADDRESS_WIDTH(32), .L2_BUS_WIDTH(32)) bus();

    l2_access_arbiter #(.ADDRESS_WIDTH(32), .L2_BUS_WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Driver tasks
    task automatic drive_idle();
        bus.IC_RD_VALID      = 1'b0; bus.IC_RD_ADDR = '0;
        bus.DC_RD_VALID      = 1'b0; bus.DC_RD_ADDR = '0;
        bus.DC_WR_VALID      = 1'b0; bus.DC_WR_ADDR = '0; bus.DC_WR_DATA = '0;
        bus.L2_RD_ADDR_READY = 1'b0; bus.L2_DATA_VALID = 1'b0; bus.L2_DATA = '0;
        bus.L2_WR_READY      = 1'b0; bus.L2_WR_COMPLETE = 1'b0;
    endtask

    // Two reset edges; returns at a falling edge with RST low and the DUT idle.
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        drive_idle();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.IC_RD_VALID = 1'b1; bus.DC_RD_VALID = 1'b1; bus.DC_WR_VALID = 1'b1;
        bus.L2_RD_ADDR_READY = 1'b1; bus.L2_DATA_VALID = 1'b1; bus.L2_WR_READY = 1'b1;
        bus.L2_WR_COMPLETE = 1'b1; bus.L2_DATA = 32'hFFFF_FFFF;
        repeat (2) @(negedge CLK);
        #1;
        n_cmp++;
        if ({bus.IC_RD_READY, bus.DC_RD_READY, bus.DC_WR_READY, bus.DC_WR_COMPLETE,
             bus.IC_RD_DATA_VALID, bus.DC_RD_DATA_VALID, bus.L2_RD_ADDR_VALID,
             bus.L2_DATA_READY, bus.L2_WR_VALID} !== 9'b0) begin
            n_fail++;
            $display("FAIL rst_ctrl_outputs: got %b required 000000000",
                     {bus.IC_RD_READY, bus.DC_RD_READY, bus.DC_WR_READY, bus.DC_WR_COMPLETE,
                      bus.IC_RD_DATA_VALID, bus.DC_RD_DATA_VALID, bus.L2_RD_ADDR_VALID,
                      bus.L2_DATA_READY, bus.L2_WR_VALID});
        end
        n_cmp++;
        if ({bus.RD_DATA_OUT, bus.L2_WR_DATA} !== 64'h0) begin
            n_fail++; $display("FAIL rst_data_regs: got %h/%h required 0/0", bus.RD_DATA_OUT, bus.L2_WR_DATA);
        end
        n_cmp++;
        if ({bus.L2_RD_ADDR, bus.L2_WR_ADDR} !== 60'h0) begin
            n_fail++; $display("FAIL rst_addr_regs: got %h/%h required 0/0", bus.L2_RD_ADDR, bus.L2_WR_ADDR);
        end
        n_cmp++;
        if (state_dbg !== 3'd0) begin
            n_fail++; $display("FAIL rst_state: got %0d required 0", state_dbg);
        end
        // First simultaneous request after reset goes to the IC.
        @(negedge CLK);
        RST = 1'b0;
        bus.L2_RD_ADDR_READY = 1'b0; bus.L2_DATA_VALID = 1'b0; bus.L2_WR_READY = 1'b0;
        bus.L2_WR_COMPLETE = 1'b0;
        #1;
        n_cmp++;
        if ({bus.DC_WR_READY, bus.DC_RD_READY, bus.IC_RD_READY} !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_first_grant: got %b required 001", {bus.DC_WR_READY, bus.DC_RD_READY, bus.IC_RD_READY});
        end
        do_reset();
    endtask

    task automatic test_ic_read();
        logic [31:0] exp;
        bus.IC_RD_VALID = 1'b1; bus.IC_RD_ADDR = 30'h40;
        #1;
        n_cmp++;
        if (bus.IC_RD_READY !== 1'b1) begin
            n_fail++; $display("FAIL ic_ready: got %b required 1", bus.IC_RD_READY);
        end
        @(negedge CLK);
        bus.IC_RD_VALID = 1'b0; bus.IC_RD_ADDR = 30'h3FF;
        bus.L2_RD_ADDR_READY = 1'b1;
        #1;
        n_cmp++;
        if ({bus.L2_RD_ADDR_VALID, bus.IC_RD_READY} !== 2'b10) begin
            n_fail++; $display("FAIL ic_addr_valid: got %b required 10", {bus.L2_RD_ADDR_VALID, bus.IC_RD_READY});
        end
        n_cmp++;
        if (bus.L2_RD_ADDR !== 30'h40) begin
            n_fail++; $display("FAIL ic_l2_addr: got %h required 40", bus.L2_RD_ADDR);
        end
        @(negedge CLK);
        bus.L2_RD_ADDR_READY = 1'b0;
        #1;
        n_cmp++;
        if ({bus.L2_DATA_READY, bus.L2_RD_ADDR_VALID, state_dbg} !== {2'b10, 3'd2}) begin
            n_fail++; $display("FAIL ic_rd_data_state: got %b required 10010", {bus.L2_DATA_READY, bus.L2_RD_ADDR_VALID, state_dbg});
        end
        @(negedge CLK);
        bus.L2_DATA_VALID = 1'b1; bus.L2_DATA = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge CLK);
        bus.L2_DATA_VALID = 1'b0; bus.L2_DATA = 32'h0;
        #1;
        n_cmp++;
        if ({bus.IC_RD_DATA_VALID, bus.DC_RD_DATA_VALID, state_dbg} !== {2'b10, 3'd0}) begin
            n_fail++; $display("FAIL ic_data_pulse: got %b required 10000", {bus.IC_RD_DATA_VALID, bus.DC_RD_DATA_VALID, state_dbg});
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_cmp++;
        if (bus.RD_DATA_OUT !== exp) begin
            n_fail++; $display("FAIL ic_data_word: got %h required %h", bus.RD_DATA_OUT, exp);
        end
        @(negedge CLK);
        #1;
        n_cmp++;
        if ({bus.IC_RD_DATA_VALID, bus.RD_DATA_OUT} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL ic_data_hold: got %b/%h required 0/deadbeef", bus.IC_RD_DATA_VALID, bus.RD_DATA_OUT);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp;
        do_reset();
        bus.IC_RD_VALID = 1'b1; bus.IC_RD_ADDR = 30'h100;
        bus.DC_RD_VALID = 1'b1; bus.DC_RD_ADDR = 30'h200;
        bus.DC_WR_VALID = 1'b1; bus.DC_WR_ADDR = 30'h10; bus.DC_WR_DATA = 32'h1234_5678;
        bus.L2_RD_ADDR_READY = 1'b1; bus.L2_DATA_VALID = 1'b1;
        bus.L2_WR_READY = 1'b1; bus.L2_WR_COMPLETE = 1'b1;
        exp_q.push_back(32'h1000_0002);
        exp_q.push_back(32'h1000_0005);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge CLK);
            bus.L2_DATA = 32'h1000_0000 + 32'(c);
            #1;
            n_cmp++;
            if (state_dbg !== RR_STATE[c]) begin
                n_fail++; $display("FAIL rr_state c%0d: got %0d required %0d", c, state_dbg, RR_STATE[c]);
            end
            n_cmp++;
            if ({bus.DC_WR_READY, bus.DC_RD_READY, bus.IC_RD_READY} !== RR_RDY[c]) begin
                n_fail++; $display("FAIL rr_ready c%0d: got %b required %b", c,
                                   {bus.DC_WR_READY, bus.DC_RD_READY, bus.IC_RD_READY}, RR_RDY[c]);
            end
            n_cmp++;
            if ({bus.DC_WR_COMPLETE, bus.DC_RD_DATA_VALID, bus.IC_RD_DATA_VALID} !== RR_PULSE[c]) begin
                n_fail++; $display("FAIL rr_pulse c%0d: got %b required %b", c,
                                   {bus.DC_WR_COMPLETE, bus.DC_RD_DATA_VALID, bus.IC_RD_DATA_VALID}, RR_PULSE[c]);
            end
            if (RR_PULSE[c][1:0] != 2'b00) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                n_cmp++;
                if (bus.RD_DATA_OUT !== exp) begin
                    n_fail++; $display("FAIL rr_data c%0d: got %h required %h", c, bus.RD_DATA_OUT, exp);
                end
            end
            if (c == 1 || c == 4) begin
                n_cmp++;
                if (bus.L2_RD_ADDR !== ((c == 1) ? 30'h100 : 30'h200)) begin
                    n_fail++; $display("FAIL rr_rd_addr c%0d: got %h", c, bus.L2_RD_ADDR);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if ({bus.L2_WR_VALID, bus.L2_WR_ADDR, bus.L2_WR_DATA} !== {1'b1, 30'h10, 32'h1234_5678}) begin
                    n_fail++; $display("FAIL rr_wr_bus: got %b/%h/%h required 1/10/12345678",
                                       bus.L2_WR_VALID, bus.L2_WR_ADDR, bus.L2_WR_DATA);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_wr_stall();
        bus.DC_WR_VALID = 1'b1; bus.DC_WR_ADDR = 30'h20; bus.DC_WR_DATA = 32'hCAFE_F00D;
        #1;
        n_cmp++;
        if (bus.DC_WR_READY !== 1'b1) begin
            n_fail++; $display("FAIL wr_ready: got %b required 1", bus.DC_WR_READY);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            bus.DC_WR_VALID = 1'b0; bus.DC_WR_ADDR = 30'h3A5A; bus.DC_WR_DATA = 32'h0BAD_0BAD;
            bus.L2_WR_READY = (i == 5);
            bus.L2_WR_COMPLETE = (i < 5);   // stray completes while still in WR_ADDR
            #1;
            n_cmp++;
            if ({bus.L2_WR_VALID, bus.L2_WR_ADDR, bus.L2_WR_DATA, bus.DC_WR_COMPLETE}
                !== {1'b1, 30'h20, 32'hCAFE_F00D, 1'b0}) begin
                n_fail++; $display("FAIL wr_stall c%0d: got %b/%h/%h/%b required 1/20/cafef00d/0", i,
                                   bus.L2_WR_VALID, bus.L2_WR_ADDR, bus.L2_WR_DATA, bus.DC_WR_COMPLETE);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            bus.L2_WR_READY = 1'b0; bus.L2_WR_COMPLETE = 1'b0;
            #1;
            n_cmp++;
            if ({bus.L2_WR_VALID, bus.DC_WR_COMPLETE, state_dbg} !== {2'b00, 3'd4}) begin
                n_fail++; $display("FAIL wr_wait c%0d: got %b required 00100", i, {bus.L2_WR_VALID, bus.DC_WR_COMPLETE, state_dbg});
            end
        end
        @(negedge CLK);
        bus.L2_WR_COMPLETE = 1'b1;
        @(negedge CLK);
        bus.L2_WR_COMPLETE = 1'b0;
        #1;
        n_cmp++;
        if ({bus.DC_WR_COMPLETE, state_dbg} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL wr_complete: got %b required 1000", {bus.DC_WR_COMPLETE, state_dbg});
        end
        @(negedge CLK);
        #1;
        n_cmp++;
        if (bus.DC_WR_COMPLETE !== 1'b0) begin
            n_fail++; $display("FAIL wr_complete_once: got %b required 0", bus.DC_WR_COMPLETE);
        end
    endtask

    task automatic test_spurious_and_reset();
        logic [31:0] exp;
        do_reset();
        bus.DC_RD_VALID = 1'b1; bus.DC_RD_ADDR = 30'h33;
        #1;
        n_cmp++;
        if ({bus.DC_WR_READY, bus.DC_RD_READY, bus.IC_RD_READY} !== 3'b010) begin
            n_fail++; $display("FAIL dc_ready: got %b required 010", {bus.DC_WR_READY, bus.DC_RD_READY, bus.IC_RD_READY});
        end
        @(negedge CLK);
        bus.DC_RD_VALID = 1'b0; bus.L2_RD_ADDR_READY = 1'b1;
        #1;
        n_cmp++;
        if (bus.L2_RD_ADDR !== 30'h33) begin
            n_fail++; $display("FAIL dc_l2_addr: got %h required 33", bus.L2_RD_ADDR);
        end
        @(negedge CLK);
        bus.L2_RD_ADDR_READY = 1'b0; bus.L2_DATA_VALID = 1'b1; bus.L2_DATA = 32'h55AA_55AA;
        exp_q.push_back(32'h55AA_55AA);
        @(negedge CLK);
        bus.L2_DATA_VALID = 1'b0;
        #1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_cmp++;
        if ({bus.DC_RD_DATA_VALID, bus.IC_RD_DATA_VALID, bus.RD_DATA_OUT} !== {2'b10, exp}) begin
            n_fail++; $display("FAIL dc_data: got %b%b/%h required 10/%h",
                               bus.DC_RD_DATA_VALID, bus.IC_RD_DATA_VALID, bus.RD_DATA_OUT, exp);
        end
        // Stray read data while idle must be dropped.
        @(negedge CLK);
        bus.L2_DATA_VALID = 1'b1; bus.L2_DATA = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            #1;
            n_cmp++;
            if ({bus.IC_RD_DATA_VALID, bus.DC_RD_DATA_VALID, bus.RD_DATA_OUT, state_dbg}
                !== {2'b00, 32'h55AA_55AA, 3'd0}) begin
                n_fail++; $display("FAIL spurious c%0d: got %b%b/%h/%0d required 00/55aa55aa/0", i,
                                   bus.IC_RD_DATA_VALID, bus.DC_RD_DATA_VALID, bus.RD_DATA_OUT, state_dbg);
            end
        end
        // Reset while waiting for read data abandons the read.
        bus.L2_DATA_VALID = 1'b0;
        bus.IC_RD_VALID = 1'b1; bus.IC_RD_ADDR = 30'h44;
        @(negedge CLK);
        bus.IC_RD_VALID = 1'b0; bus.L2_RD_ADDR_READY = 1'b1;
        @(negedge CLK);
        bus.L2_RD_ADDR_READY = 1'b0;
        #1;
        n_cmp++;
        if (state_dbg !== 3'd2) begin
            n_fail++; $display("FAIL rst_mid_pre_state: got %0d required 2", state_dbg);
        end
        RST = 1'b1; bus.L2_DATA_VALID = 1'b1; bus.L2_DATA = 32'h7777_7777;
        @(negedge CLK);
        RST = 1'b0; bus.L2_DATA_VALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if ({bus.IC_RD_DATA_VALID, bus.DC_RD_DATA_VALID, bus.RD_DATA_OUT, state_dbg}
                !== {2'b00, 32'h0, 3'd0}) begin
                n_fail++; $display("FAIL rst_mid c%0d: got %b%b/%h/%0d required 00/00000000/0", i,
                                   bus.IC_RD_DATA_VALID, bus.DC_RD_DATA_VALID, bus.RD_DATA_OUT, state_dbg);
            end
            @(negedge CLK);
        end
    endtask

    // Sequence and final report
    initial begin
        drive_idle();
        test_reset();
        test_ic_read();
        test_round_robin();
        test_wr_stall();
        test_spurious_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
